// File: rtl/regfile_sb.sv
// Register file with two write ports, two bypassed read ports and a per-register
// busy scoreboard that produces the decode stall. R0 always reads as zero.
module regfile_sb #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    input  logic          wr0_en,
    input  logic [AW-1:0] wr0_addr,
    input  logic [DW-1:0] wr0_data,
    input  logic          wr1_en,
    input  logic [AW-1:0] wr1_addr,
    input  logic [DW-1:0] wr1_data,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_addr,
    output logic          ra_busy,
    output logic          rb_busy,
    output logic          stall,
    output logic [AW:0]   busy_cnt
);

    logic [DW-1:0]    regs     [DEPTH];
    logic [DW-1:0]    fwd_data [DEPTH];
    logic [DEPTH-1:0] busy_bit;
    logic [DEPTH-1:0] busy_eff;
    logic [DEPTH-1:0] busy_next;
    logic [DEPTH-1:0] wr0_hit;
    logic [DEPTH-1:0] wr1_hit;
    logic [AW:0]      cnt_next;

    // Per-register write decode; R0 is never a write target.
    always_comb begin
        wr0_hit = '0;
        wr1_hit = '0;
        for (int i = 1; i < DEPTH; i++) begin
            wr0_hit[i] = wr0_en && (wr0_addr == AW'(i));
            wr1_hit[i] = wr1_en && (wr1_addr == AW'(i));
        end
    end

    // Bypassed view of every register, with the load port taking priority.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fwd_data[i] = '0;
            if (i != 0) begin
                if (wr1_hit[i]) begin
                    fwd_data[i] = wr1_data;
                end else if (wr0_hit[i]) begin
                    fwd_data[i] = wr0_data;
                end else begin
                    fwd_data[i] = regs[i];
                end
            end
        end
    end

    // A write landing this cycle releases its register for same-cycle consumers.
    assign busy_eff = busy_bit & ~wr0_hit & ~wr1_hit;

    assign ra_data = fwd_data[ra_addr];
    assign rb_data = fwd_data[rb_addr];
    assign ra_busy = busy_eff[ra_addr];
    assign rb_busy = busy_eff[rb_addr];
    assign stall   = iss_en & (ra_busy | rb_busy | busy_eff[iss_addr]);

    // Applying the set after the clears lets a new issue win over a write.
    always_comb begin
        busy_next = busy_bit & ~(wr0_hit | wr1_hit);
        if (iss_en && !stall && (iss_addr != '0)) begin
            busy_next[iss_addr] = 1'b1;
        end
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy_bit <= '0;
            busy_cnt <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr1_hit[i]) begin
                    regs[i] <= wr1_data;
                end else if (wr0_hit[i]) begin
                    regs[i] <= wr0_data;
                end
            end
            busy_bit <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

endmodule
